// File: rtl/riscv_pkg.sv
// ============================================================================
//  Module   : riscv_pkg
//  Brief    : Shared constants and response-tag type for the data-memory
//             arbiter of riscv_core.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package riscv_pkg;

   // Requester indices as seen on the arbiter's winner select
   localparam logic PORT_CORE = 1'b0;
   localparam logic PORT_HOST = 1'b1;

   // Byte-enable width of the 32-bit data path
   localparam int WSTRB_W = 4;

   // Tag captured on every grant, consumed one cycle later to route the
   // response back to its requester
   typedef struct packed {
      logic valid;
      logic port;
      logic err;
      logic was_read;
   } rsp_tag_t;

   // RAM byte enables for an access: reads never write
   function automatic logic [WSTRB_W-1:0] we_mask(input logic          we,
                                                  input logic [WSTRB_W-1:0] strb);
      return we ? strb : '0;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
//  Module   : dmem_arbiter_if
//  Brief    : Requester-side bus of the data-memory arbiter: port 0 (core
//             LSU) and port 1 (host/loader), request and response signals.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
   parameter int ADDR_W = 12
) ();
   import riscv_pkg::*;

   // Port 0: core load/store unit
   logic                p0_req;
   logic                p0_we;
   logic [ADDR_W-1:0]   p0_addr;
   logic [31:0]         p0_wdata;
   logic [WSTRB_W-1:0]  p0_wstrb;
   logic                p0_gnt;
   logic                p0_rvalid;
   logic [31:0]         p0_rdata;
   logic                p0_rerr;

   // Port 1: host / loader
   logic                p1_req;
   logic                p1_we;
   logic [ADDR_W-1:0]   p1_addr;
   logic [31:0]         p1_wdata;
   logic [WSTRB_W-1:0]  p1_wstrb;
   logic                p1_gnt;
   logic                p1_rvalid;
   logic [31:0]         p1_rdata;
   logic                p1_rerr;

   // Requesters drive the access, observe grant and response
   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata, p0_wstrb,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_wstrb,
      input  p0_gnt, p0_rvalid, p0_rdata, p0_rerr,
      input  p1_gnt, p1_rvalid, p1_rdata, p1_rerr
   );

   // The arbiter consumes requests, produces grant and response
   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata, p0_wstrb,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_wstrb,
      output p0_gnt, p0_rvalid, p0_rdata, p0_rerr,
      output p1_gnt, p1_rvalid, p1_rdata, p1_rerr
   );

endinterface

`default_nettype wire

// File: rtl/dmem_arb_pick.sv
// ============================================================================
//  Module   : dmem_arb_pick
//  Brief    : Combinational winner selection. Port 0 has fixed priority
//             unless the starvation-force flag hands the slot to port 1.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arb_pick
   import riscv_pkg::*;
(
   input  wire logic i_req0,
   input  wire logic i_req1,
   input  wire logic i_force,
   output logic      o_win,
   output logic      o_valid
);

   // Forced port 1 first, then port 0, then port 1
   always_comb begin
      o_win   = PORT_CORE;
      o_valid = 1'b0;
      if (i_force && i_req1) begin
         o_win   = PORT_HOST;
         o_valid = 1'b1;
      end else if (i_req0) begin
         o_win   = PORT_CORE;
         o_valid = 1'b1;
      end else if (i_req1) begin
         o_win   = PORT_HOST;
         o_valid = 1'b1;
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
//  Module   : dmem_arbiter
//  Brief    : Two-requester arbiter for the single-port synchronous data RAM
//             of riscv_core. One access per cycle, zero-latency grant,
//             one-cycle response routed back to the issuing port.
//             Out-of-range addresses are answered with rerr and never reach
//             the RAM.
//  Options  : DMEM_ARB_STARVE_GUARD_EN - after STARVE_LIMIT consecutive
//             denials port 1 is forced to win the next arbitration.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
   import riscv_pkg::*;
#(
   parameter int ADDR_W       = 12,
   parameter int DEPTH        = 4096,
   parameter int STARVE_LIMIT = 8
) (
   input  wire logic           clk,
   input  wire logic           rst,        // asynchronous, active low
   dmem_arbiter_if.slave       bus,
   output logic                mem_en,
   output logic [WSTRB_W-1:0]  mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [31:0]         mem_wdata,
   input  wire logic [31:0]    mem_rdata
);

   // One extra bit so DEPTH == 2**ADDR_W stays representable
   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

   logic                w_force;
   logic                w_win;
   logic                w_valid;
   logic                w_grant;
   logic                w_we;
   logic [ADDR_W-1:0]   w_addr;
   logic [31:0]         w_wdata;
   logic [WSTRB_W-1:0]  w_wstrb;
   logic                w_in_range;
   logic                w_rd_ok;
   logic [31:0]         w_rdata;
   rsp_tag_t            r_rsp;

   dmem_arb_pick u_pick (
      .i_req0  (bus.p0_req),
      .i_req1  (bus.p1_req),
      .i_force (w_force),
      .o_win   (w_win),
      .o_valid (w_valid)
   );

   // No access is accepted while reset is held
   assign w_grant    = w_valid & rst;
   assign bus.p0_gnt = w_grant & (w_win == PORT_CORE);
   assign bus.p1_gnt = w_grant & (w_win == PORT_HOST);

   // Route the winning requester's access fields
   always_comb begin
      w_we    = bus.p0_we;
      w_addr  = bus.p0_addr;
      w_wdata = bus.p0_wdata;
      w_wstrb = bus.p0_wstrb;
      if (w_win == PORT_HOST) begin
         w_we    = bus.p1_we;
         w_addr  = bus.p1_addr;
         w_wdata = bus.p1_wdata;
         w_wstrb = bus.p1_wstrb;
      end
   end

   assign w_in_range = ({1'b0, w_addr} < c_DEPTH);

   // Drive the RAM only for granted in-range accesses; idle bus is all zero
   always_comb begin
      mem_en    = 1'b0;
      mem_we    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (w_grant) begin
         mem_addr  = w_addr;
         mem_wdata = w_wdata;
         if (w_in_range) begin
            mem_en = 1'b1;
            mem_we = we_mask(w_we, w_wstrb);
         end
      end
   end

   // Capture the response tag on every grant; an idle cycle clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rsp <= '0;
      end else if (w_grant) begin
         r_rsp <= {1'b1, w_win, ~w_in_range, ~w_we};
      end else begin
         r_rsp <= '0;
      end
   end

   // RAM data is only meaningful for in-range reads
   assign w_rd_ok = r_rsp.valid & ~r_rsp.err & r_rsp.was_read;
   assign w_rdata = w_rd_ok ? mem_rdata : 32'h0;

   assign bus.p0_rvalid = r_rsp.valid & (r_rsp.port == PORT_CORE);
   assign bus.p1_rvalid = r_rsp.valid & (r_rsp.port == PORT_HOST);
   assign bus.p0_rerr   = bus.p0_rvalid & r_rsp.err;
   assign bus.p1_rerr   = bus.p1_rvalid & r_rsp.err;
   assign bus.p0_rdata  = bus.p0_rvalid ? w_rdata : 32'h0;
   assign bus.p1_rdata  = bus.p1_rvalid ? w_rdata : 32'h0;

`ifdef DMEM_ARB_STARVE_GUARD_EN
   localparam int                 c_CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

   logic [c_CNT_W-1:0] r_starve_cnt;

   // Count consecutive denials of a pending port 1 request, saturating
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_starve_cnt <= '0;
      end else if (!bus.p1_req || (w_grant && (w_win == PORT_HOST))) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != c_LIMIT) begin
         r_starve_cnt <= r_starve_cnt + c_CNT_W'(1);
      end
   end

   assign w_force = (r_starve_cnt == c_LIMIT);
`else
   logic w_unused_starve;

   assign w_force         = 1'b0;
   assign w_unused_starve = |STARVE_LIMIT;
`endif

endmodule

`default_nettype wire
